// File: rtl/pcs_am_pkg.sv
// Shared constants for the PCS alignment-marker datapath: default lane geometry and the
// helper that locates a lane's BIP field inside a packed multi-lane bus.
package pcs_am_pkg;

  localparam int unsigned NB_BIP  = 8;
  localparam int unsigned N_LANES = 20;

  // Lane k occupies bits [lane_lsb(k) +: nb_bip] of a packed BIP bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned nb_bip);
    return lane * nb_bip;
  endfunction

endpackage

// File: rtl/bip_mismatch_popcount.sv
// Number of bit positions in which a received BIP differs from the locally computed one.
module bip_mismatch_popcount #(
  parameter int unsigned NB_BIP = 8,
  parameter int unsigned NB_INC = $clog2(NB_BIP) + 1
) (
  input  logic [NB_BIP-1:0] i_received,
  input  logic [NB_BIP-1:0] i_calculated,
  output logic [NB_INC-1:0] o_count
);

  logic [NB_BIP-1:0] diff;

  always_comb begin
    diff    = i_received ^ i_calculated;
    o_count = '0;
    for (int unsigned b = 0; b < NB_BIP; b++) begin
      o_count = o_count + NB_INC'(diff[b]);
    end
  end

endmodule

// File: rtl/multilane_bip_error_counter.sv
// Per-lane BIP error accounting: popcount stage, then saturating accumulate stage, with
// clear-on-read counters that never lose an increment landing on the read cycle.
module multilane_bip_error_counter
  import pcs_am_pkg::*;
#(
  parameter int unsigned NB_BIP      = pcs_am_pkg::NB_BIP,
  parameter int unsigned N_LANES     = pcs_am_pkg::N_LANES,
  parameter int unsigned NB_COUNTER  = 32,
  parameter int unsigned NB_LANE_SEL = $clog2(N_LANES)
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic [N_LANES-1:0]          i_am_valid,
  input  logic [N_LANES*NB_BIP-1:0]   i_received_bip,
  input  logic [N_LANES*NB_BIP-1:0]   i_calculated_bip,
  input  logic                        i_rd_req,
  input  logic [NB_LANE_SEL-1:0]      i_rd_lane,
  output logic                        o_rd_valid,
  output logic [NB_COUNTER-1:0]       o_rd_count,
  output logic                        o_rd_sat,
  output logic [N_LANES-1:0]          o_sat_flags,
  output logic [N_LANES-1:0]          o_am_error
);

  localparam int unsigned NB_INC = $clog2(NB_BIP) + 1;
  localparam int unsigned NB_SUM = NB_COUNTER + 1;
  localparam logic [NB_SUM-1:0] SAT_LIMIT = {1'b0, {NB_COUNTER{1'b1}}};

  logic [NB_INC-1:0]     inc_now [N_LANES];
  logic [NB_INC-1:0]     inc_q   [N_LANES];
  logic [N_LANES-1:0]    v_q;
  logic [N_LANES-1:0]    inc_nz;
  logic [NB_SUM-1:0]     sum     [N_LANES];
  logic [NB_COUNTER-1:0] cnt_q   [N_LANES];
  logic [NB_COUNTER-1:0] cnt_d   [N_LANES];
  logic [N_LANES-1:0]    sat_q, sat_d;
  logic [N_LANES-1:0]    am_error_q;
  logic [N_LANES-1:0]    rd_hit;
  logic [NB_COUNTER-1:0] rd_cnt_sel;
  logic                  rd_sat_sel;
  logic                  rd_valid_q;
  logic [NB_COUNTER-1:0] rd_count_q;
  logic                  rd_sat_q;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    bip_mismatch_popcount #(
      .NB_BIP (NB_BIP),
      .NB_INC (NB_INC)
    ) u_popcount (
      .i_received   (i_received_bip[lane_lsb(k, NB_BIP) +: NB_BIP]),
      .i_calculated (i_calculated_bip[lane_lsb(k, NB_BIP) +: NB_BIP]),
      .o_count      (inc_now[k])
    );
  end

  always_comb begin
    rd_cnt_sel = '0;
    rd_sat_sel = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      rd_hit[k] = i_rd_req && (i_rd_lane == NB_LANE_SEL'(k));
      inc_nz[k] = |inc_q[k];
      sum[k]    = {1'b0, cnt_q[k]} + NB_SUM'(inc_q[k]);
      cnt_d[k]  = cnt_q[k];
      sat_d[k]  = sat_q[k];
      if (i_rd_lane == NB_LANE_SEL'(k)) begin
        rd_cnt_sel = cnt_q[k];
        rd_sat_sel = sat_q[k];
      end
      // A read restarts the lane from whatever stage 2 delivers on the same edge.
      if (rd_hit[k]) begin
        cnt_d[k] = v_q[k] ? NB_COUNTER'(inc_q[k]) : '0;
        sat_d[k] = 1'b0;
      end else if (v_q[k]) begin
        if (sum[k] >= SAT_LIMIT) begin
          cnt_d[k] = '1;
          sat_d[k] = 1'b1;
        end else begin
          cnt_d[k] = sum[k][NB_COUNTER-1:0];
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < N_LANES; k++) begin
        inc_q[k] <= '0;
        cnt_q[k] <= '0;
      end
      v_q        <= '0;
      sat_q      <= '0;
      am_error_q <= '0;
      rd_valid_q <= 1'b0;
      rd_count_q <= '0;
      rd_sat_q   <= 1'b0;
    end else begin
      for (int k = 0; k < N_LANES; k++) begin
        inc_q[k] <= inc_now[k];
        cnt_q[k] <= cnt_d[k];
      end
      v_q        <= {N_LANES{i_enable}} & i_am_valid;
      sat_q      <= sat_d;
      am_error_q <= v_q & inc_nz;
      rd_valid_q <= i_rd_req;
      if (i_rd_req) begin
        rd_count_q <= rd_cnt_sel;
        rd_sat_q   <= rd_sat_sel;
      end
    end
  end

  assign o_rd_valid  = rd_valid_q;
  assign o_rd_count  = rd_count_q;
  assign o_rd_sat    = rd_sat_q;
  assign o_sat_flags = sat_q;
  assign o_am_error  = am_error_q;

endmodule

// File: tb/tb_multilane_bip_error_counter.sv
// Bench for multilane_bip_error_counter: a 32-bit and a 4-bit counter instance share stimulus
// and are checked against an event-level model of the per-lane error totals.
module tb_multilane_bip_error_counter;

  localparam int unsigned NB   = 8;
  localparam int unsigned NL   = 20;
  localparam int unsigned NSEL = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [NL-1:0]    am_valid;
  logic [NL*NB-1:0] recv;
  logic [NL*NB-1:0] calc;
  logic             rd_req;
  logic [NSEL-1:0]  rd_lane;

  logic             rd_valid_w, rd_sat_w;
  logic [31:0]      rd_count_w;
  logic [NL-1:0]    sat_flags_w, am_error_w;
  logic             rd_valid_n, rd_sat_n;
  logic [3:0]       rd_count_n;
  logic [NL-1:0]    sat_flags_n, am_error_n;

  int checks   = 0;
  int failures = 0;

  // Model: per-instance error totals, plus the AM results still in flight.
  longint unsigned m_cnt [2][NL];
  bit [NL-1:0]     m_sat [2];
  longint unsigned m_max [2];
  int              p_inc [NL];
  bit [NL-1:0]     p_v;
  bit [NL-1:0]     e_am;
  bit              e_rd_valid;
  longint unsigned e_rd_cnt [2];
  bit              e_rd_sat [2];

  multilane_bip_error_counter #(
    .NB_BIP     (NB),
    .N_LANES    (NL),
    .NB_COUNTER (32)
  ) u_dut_wide (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_enable         (enable),
    .i_am_valid       (am_valid),
    .i_received_bip   (recv),
    .i_calculated_bip (calc),
    .i_rd_req         (rd_req),
    .i_rd_lane        (rd_lane),
    .o_rd_valid       (rd_valid_w),
    .o_rd_count       (rd_count_w),
    .o_rd_sat         (rd_sat_w),
    .o_sat_flags      (sat_flags_w),
    .o_am_error       (am_error_w)
  );

  multilane_bip_error_counter #(
    .NB_BIP     (NB),
    .N_LANES    (NL),
    .NB_COUNTER (4)
  ) u_dut_narrow (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_enable         (enable),
    .i_am_valid       (am_valid),
    .i_received_bip   (recv),
    .i_calculated_bip (calc),
    .i_rd_req         (rd_req),
    .i_rd_lane        (rd_lane),
    .o_rd_valid       (rd_valid_n),
    .o_rd_count       (rd_count_n),
    .o_rd_sat         (rd_sat_n),
    .o_sat_flags      (sat_flags_n),
    .o_am_error       (am_error_n)
  );

  always #5 clk = ~clk;

  function automatic void model_edge();
    int lane;
    longint unsigned total;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < NL; k++) m_cnt[i][k] = 0;
        m_sat[i]    = '0;
        e_rd_cnt[i] = 0;
        e_rd_sat[i] = 1'b0;
      end
      for (int k = 0; k < NL; k++) p_inc[k] = 0;
      p_v        = '0;
      e_am       = '0;
      e_rd_valid = 1'b0;
      return;
    end
    lane       = int'(rd_lane);
    e_rd_valid = rd_req;
    for (int i = 0; i < 2; i++) begin
      if (rd_req) begin
        e_rd_cnt[i] = 0;
        e_rd_sat[i] = 1'b0;
        if (lane < NL) begin
          e_rd_cnt[i] = m_cnt[i][lane];
          e_rd_sat[i] = m_sat[i][lane];
        end
      end
      for (int k = 0; k < NL; k++) begin
        if (rd_req && lane == k) begin
          m_cnt[i][k] = p_v[k] ? longint'(p_inc[k]) : 0;
          m_sat[i][k] = 1'b0;
        end else if (p_v[k]) begin
          total = m_cnt[i][k] + longint'(p_inc[k]);
          if (total >= m_max[i]) begin
            m_cnt[i][k] = m_max[i];
            m_sat[i][k] = 1'b1;
          end else begin
            m_cnt[i][k] = total;
          end
        end
      end
    end
    for (int k = 0; k < NL; k++) begin
      e_am[k]  = p_v[k] && (p_inc[k] != 0);
      p_inc[k] = $countones(recv[k*NB +: NB] ^ calc[k*NB +: NB]);
      p_v[k]   = enable && am_valid[k];
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    am_valid = '0;
    recv     = '0;
    calc     = '0;
    rd_req   = 1'b0;
    rd_lane  = '0;
  endtask

  task automatic set_lane(input int k, input logic [NB-1:0] r, input logic [NB-1:0] c);
    recv[k*NB +: NB] = r;
    calc[k*NB +: NB] = c;
    am_valid[k]      = 1'b1;
  endtask

  task automatic read_lane(input int k);
    clear_inputs();
    rd_req  = 1'b1;
    rd_lane = NSEL'(k);
    step();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    enable  = 1'b1;
    rst     = 1'b1;
    rd_req  = 1'b1;
    rd_lane = 3;
    step();
    step();
    rst = 1'b0;
    clear_inputs();
    checks++;
    if ({rd_valid_w, rd_count_w, rd_sat_w, sat_flags_w, am_error_w} !== '0) begin
      failures++;
      $display("FAIL reset_wide: got %h required 0",
               {rd_valid_w, rd_count_w, rd_sat_w, sat_flags_w, am_error_w});
    end
    checks++;
    if ({rd_valid_n, rd_count_n, rd_sat_n, sat_flags_n, am_error_n} !== '0) begin
      failures++;
      $display("FAIL reset_narrow: got %h required 0",
               {rd_valid_n, rd_count_n, rd_sat_n, sat_flags_n, am_error_n});
    end
  endtask

  task automatic test_single_lane();
    clear_inputs();
    set_lane(3, 8'hFF, 8'h0F);
    step();
    clear_inputs();
    step();
    checks++;
    if (am_error_w !== 20'h00008 || am_error_n !== 20'h00008) begin
      failures++;
      $display("FAIL am_error_pulse: got %h/%h required 00008", am_error_w, am_error_n);
    end
    step();
    checks++;
    if (am_error_w !== '0 || am_error_n !== '0) begin
      failures++;
      $display("FAIL am_error_single: got %h/%h required 0", am_error_w, am_error_n);
    end
    read_lane(3);
    checks++;
    if (rd_valid_w !== 1'b1 || rd_count_w !== 32'd4 || rd_count_n !== 4'd4 || rd_sat_w !== 1'b0) begin
      failures++;
      $display("FAIL lane3_count: got v=%b %0d/%0d required v=1 4/4", rd_valid_w, rd_count_w,
               rd_count_n);
    end
    step();
    checks++;
    if (rd_valid_w !== 1'b0 || rd_count_w !== 32'd4) begin
      failures++;
      $display("FAIL read_hold: got v=%b cnt=%0d required v=0 cnt=4", rd_valid_w, rd_count_w);
    end
    read_lane(4);
    checks++;
    if (rd_valid_w !== 1'b1 || rd_count_w !== 32'd0) begin
      failures++;
      $display("FAIL other_lane_zero: got v=%b cnt=%0d required v=1 cnt=0", rd_valid_w, rd_count_w);
    end
  endtask

  task automatic test_saturation();
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 8'hFF, 8'h00);
      step();
    end
    clear_inputs();
    step();
    step();
    checks++;
    if (sat_flags_n[0] !== 1'b1 || sat_flags_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL sat_flag_set: got n=%b w=%b required n=1 w=0", sat_flags_n[0], sat_flags_w[0]);
    end
    read_lane(0);
    checks++;
    if (rd_count_n !== 4'd15 || rd_sat_n !== 1'b1 || rd_count_w !== 32'd24 || rd_sat_w !== 1'b0) begin
      failures++;
      $display("FAIL sat_read: got n=%0d/%b w=%0d/%b required n=15/1 w=24/0", rd_count_n, rd_sat_n,
               rd_count_w, rd_sat_w);
    end
    step();
    checks++;
    if (sat_flags_n[0] !== 1'b0) begin
      failures++;
      $display("FAIL sat_flag_clear: got %b required 0", sat_flags_n[0]);
    end
  endtask

  task automatic test_read_collision();
    clear_inputs();
    set_lane(5, 8'hFF, 8'h03);
    step();
    clear_inputs();
    set_lane(5, 8'h0F, 8'h00);
    step();
    clear_inputs();
    set_lane(5, 8'h03, 8'h00);
    step();
    read_lane(5);
    checks++;
    if (rd_count_w !== 32'd10 || rd_count_n !== 4'd10) begin
      failures++;
      $display("FAIL collision_first: got %0d/%0d required 10/10", rd_count_w, rd_count_n);
    end
    step();
    read_lane(5);
    checks++;
    if (rd_valid_w !== 1'b1 || rd_count_w !== 32'd2 || rd_count_n !== 4'd2) begin
      failures++;
      $display("FAIL collision_second: got v=%b %0d/%0d required v=1 2/2", rd_valid_w, rd_count_w,
               rd_count_n);
    end
  endtask

  task automatic test_enable_off();
    clear_inputs();
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < NL; k++) begin
        recv[k*NB +: NB] = NB'($urandom);
        calc[k*NB +: NB] = ~recv[k*NB +: NB];
      end
      am_valid = '1;
      step();
      checks++;
      if (am_error_w !== '0 || am_error_n !== '0 || sat_flags_n !== m_sat[1]) begin
        failures++;
        $display("FAIL enable_off_cycle%0d: got am=%h/%h sat=%h required am=0 sat=%h", c, am_error_w,
                 am_error_n, sat_flags_n, m_sat[1]);
      end
    end
    clear_inputs();
    enable = 1'b1;
    step();
    step();
    read_lane(10);
    checks++;
    if (rd_count_w !== 32'd0 || rd_count_n !== 4'd0) begin
      failures++;
      $display("FAIL enable_off_lane10: got %0d/%0d required 0/0", rd_count_w, rd_count_n);
    end
    set_lane(7, 8'h01, 8'h00);
    step();
    clear_inputs();
    enable = 1'b0;
    step();
    step();
    enable = 1'b1;
    read_lane(7);
    checks++;
    if (rd_count_w !== 32'd1 || rd_count_n !== 4'd1) begin
      failures++;
      $display("FAIL enable_inflight: got %0d/%0d required 1/1", rd_count_w, rd_count_n);
    end
  endtask

  task automatic test_bad_lane();
    clear_inputs();
    set_lane(9, 8'h07, 8'h00);
    step();
    clear_inputs();
    step();
    step();
    read_lane(20);
    checks++;
    if (rd_valid_w !== 1'b1 || rd_count_w !== '0 || rd_sat_w !== 1'b0 || rd_count_n !== '0) begin
      failures++;
      $display("FAIL bad_lane_20: got v=%b %0d/%0d required v=1 0/0", rd_valid_w, rd_count_w,
               rd_count_n);
    end
    read_lane(31);
    checks++;
    if (rd_valid_n !== 1'b1 || rd_count_n !== '0 || rd_sat_n !== 1'b0) begin
      failures++;
      $display("FAIL bad_lane_31: got v=%b cnt=%0d required v=1 cnt=0", rd_valid_n, rd_count_n);
    end
    read_lane(9);
    checks++;
    if (rd_count_w !== 32'd3 || rd_count_n !== 4'd3) begin
      failures++;
      $display("FAIL bad_lane_no_clear: got %0d/%0d required 3/3", rd_count_w, rd_count_n);
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    set_lane(1, 8'hF0, 8'h00);
    set_lane(2, 8'hAA, 8'h55);
    step();
    clear_inputs();
    step();
    step();
    read_lane(1);
    checks++;
    if (rd_valid_w !== 1'b1 || rd_count_w !== 32'd4) begin
      failures++;
      $display("FAIL b2b_lane1: got v=%b cnt=%0d required v=1 cnt=4", rd_valid_w, rd_count_w);
    end
    read_lane(2);
    checks++;
    if (rd_valid_w !== 1'b1 || rd_count_w !== 32'd8 || rd_count_n !== 4'd8) begin
      failures++;
      $display("FAIL b2b_lane2: got v=%b %0d/%0d required v=1 8/8", rd_valid_w, rd_count_w,
               rd_count_n);
    end
    read_lane(2);
    checks++;
    if (rd_valid_w !== 1'b1 || rd_count_w !== 32'd0) begin
      failures++;
      $display("FAIL b2b_reread: got v=%b cnt=%0d required v=1 cnt=0", rd_valid_w, rd_count_w);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      enable   = ($urandom_range(0, 3) != 0);
      am_valid = NL'($urandom);
      for (int k = 0; k < NL; k++) begin
        recv[k*NB +: NB] = NB'($urandom);
        calc[k*NB +: NB] = recv[k*NB +: NB] ^ (($urandom_range(0, 2) == 0) ? NB'($urandom) : NB'(0));
      end
      rd_req  = ($urandom_range(0, 9) < 3);
      rd_lane = NSEL'($urandom_range(0, NL + 3));
      step();
      checks++;
      if (am_error_w !== e_am || sat_flags_w !== m_sat[0] || rd_valid_w !== e_rd_valid ||
          rd_count_w !== 32'(e_rd_cnt[0]) || rd_sat_w !== e_rd_sat[0]) begin
        failures++;
        $display("FAIL random_wide c%0d: got am=%h sat=%h v=%b cnt=%0d s=%b required am=%h sat=%h v=%b cnt=%0d s=%b",
                 c, am_error_w, sat_flags_w, rd_valid_w, rd_count_w, rd_sat_w, e_am, m_sat[0],
                 e_rd_valid, e_rd_cnt[0], e_rd_sat[0]);
      end
      checks++;
      if (am_error_n !== e_am || sat_flags_n !== m_sat[1] || rd_valid_n !== e_rd_valid ||
          rd_count_n !== 4'(e_rd_cnt[1]) || rd_sat_n !== e_rd_sat[1]) begin
        failures++;
        $display("FAIL random_narrow c%0d: got am=%h sat=%h v=%b cnt=%0d s=%b required am=%h sat=%h v=%b cnt=%0d s=%b",
                 c, am_error_n, sat_flags_n, rd_valid_n, rd_count_n, rd_sat_n, e_am, m_sat[1],
                 e_rd_valid, e_rd_cnt[1], e_rd_sat[1]);
      end
    end
    clear_inputs();
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < NL; k++) set_lane(k, NB'($urandom), NB'($urandom));
      step();
    end
    rst     = 1'b1;
    rd_req  = 1'b1;
    rd_lane = 0;
    step();
    rst = 1'b0;
    clear_inputs();
    checks++;
    if ({rd_valid_w, rd_count_w, rd_sat_w, sat_flags_w, am_error_w} !== '0 ||
        {rd_valid_n, rd_count_n, rd_sat_n, sat_flags_n, am_error_n} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h/%h required 0",
               {rd_valid_w, rd_count_w, rd_sat_w, sat_flags_w, am_error_w},
               {rd_valid_n, rd_count_n, rd_sat_n, sat_flags_n, am_error_n});
    end
    step();
    checks++;
    if (rd_valid_w !== 1'b0 || rd_valid_n !== 1'b0 || am_error_w !== '0 || am_error_n !== '0) begin
      failures++;
      $display("FAIL reset_mid_drop: got v=%b/%b am=%h/%h required 0", rd_valid_w, rd_valid_n,
               am_error_w, am_error_n);
    end
    read_lane(0);
    checks++;
    if (rd_valid_w !== 1'b1 || rd_count_w !== '0 || rd_count_n !== '0) begin
      failures++;
      $display("FAIL reset_mid_cleared: got v=%b %0d/%0d required v=1 0/0", rd_valid_w, rd_count_w,
               rd_count_n);
    end
  endtask

  initial begin
    m_max[0] = 64'hFFFF_FFFF;
    m_max[1] = 64'd15;
    test_reset();
    test_single_lane();
    test_saturation();
    test_read_collision();
    test_enable_off();
    test_bad_lane();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/multilane_bip_error_counter.md
MULTILANE_BIP_ERROR_COUNTER -- requirements
Module: multilane_bip_error_counter

Interface
REQ-001 Parameter NB_BIP, default 8, is the BIP width per lane in bits.
REQ-002 Parameter N_LANES, default 20, is the number of PCS lanes counted independently.
REQ-003 Parameter NB_COUNTER, default 32, is the width of each per-lane error counter.
REQ-004 Parameter NB_LANE_SEL, default $clog2(N_LANES), is the width of the read lane index.
REQ-005 i_clock  in  1  clock; all logic on the rising edge.
REQ-006 i_reset  in  1  reset: synchronous, active-high.
REQ-007 i_enable  in  1  global count enable.
REQ-008 i_am_valid  in  N_LANES  per-lane strobe: an alignment-marker BIP pair is present this cycle.
REQ-009 i_received_bip  in  N_LANES*NB_BIP  received BIP values; lane k occupies bits [k*NB_BIP +: NB_BIP].
REQ-010 i_calculated_bip  in  N_LANES*NB_BIP  locally computed BIP values; same packing as i_received_bip.
REQ-011 i_rd_req  in  1  single-cycle read request; clear-on-read.
REQ-012 i_rd_lane  in  NB_LANE_SEL  lane index sampled with i_rd_req.
REQ-013 o_rd_valid  out  1  one-cycle strobe qualifying the read data.
REQ-014 o_rd_count  out  NB_COUNTER  counter value returned by the read.
REQ-015 o_rd_sat  out  1  saturation flag of the lane that was read.
REQ-016 o_sat_flags  out  N_LANES  live sticky saturation flag per lane.
REQ-017 o_am_error  out  N_LANES  per-lane strobe: an AM on that lane had at least one BIP bit mismatch.

Function
REQ-018 Stage 1 SHALL register, per lane: inc_k = popcount(received_k XOR calculated_k) of width $clog2(NB_BIP)+1, and v_k = i_enable AND i_am_valid[k].
REQ-019 Stage 2 SHALL add inc_k to counter_k when v_k=1, so a mismatch sampled at edge t is visible in counter_k after edge t+2.
REQ-020 o_am_error[k] SHALL equal v_k AND (inc_k != 0), registered in stage 2 (latency 2, one-cycle pulse).
REQ-021 The addition SHALL be performed at NB_COUNTER+1 bits; when the sum is >= 2^NB_COUNTER-1 the counter SHALL load all-ones and sat_k SHALL set.
REQ-022 A saturated counter SHALL hold all-ones, and sat_k SHALL stay set until the lane is read or reset.
REQ-023 With i_enable=0, stage-1 valids SHALL be forced to 0; entries already in stage 1 SHALL still complete.
REQ-024 On i_rd_req=1 at edge t, o_rd_valid SHALL be 1 after edge t+1 for exactly one cycle, with o_rd_count/o_rd_sat equal to counter/sat of i_rd_lane as held before edge t.
REQ-025 On the same edge t the read lane SHALL be cleared: counter := the stage-2 increment for that lane if v=1, else 0; sat := 0 (a simultaneous increment is never lost).
REQ-026 If i_rd_lane >= N_LANES, the read SHALL return o_rd_count=0 and o_rd_sat=0 with o_rd_valid=1, and no lane SHALL be cleared.
REQ-027 Back-to-back reads on consecutive cycles SHALL each be served; a re-read of the same lane returns only the errors accumulated after the first read.
REQ-028 When o_rd_valid=0, o_rd_count and o_rd_sat SHALL hold their last value.

Reset
REQ-029 i_reset SHALL clear all counters, sat flags, stage-1/2 registers, o_rd_valid, o_rd_count, o_rd_sat and o_am_error to 0.
REQ-030 i_reset SHALL take priority over accumulation and read; a read request asserted in the reset cycle SHALL be dropped.

Structure
REQ-031 NB_BIP, N_LANES and the lane-slice helper constant SHALL reside in the shared package pcs_am_pkg.
REQ-032 Per-lane popcount SHALL be a sub-module bip_mismatch_popcount (XOR plus popcount, combinational, parameter NB_BIP), instantiated N_LANES times.

Verification
REQ-033 Lane 3: received 8'hFF, calculated 8'h0F, am_valid[3]=1 for one cycle -> counter_3=4 after 2 edges, o_am_error[3] pulses once; all other lanes 0.
REQ-034 NB_COUNTER=4, lane 0 mismatches 8'hFF every cycle -> counter reads 15 (not a wrap), o_sat_flags[0]=1; read -> o_rd_count=15, o_rd_sat=1; flag cleared afterwards.
REQ-035 Lane 5 holds 10; a read of lane 5 coincides with a stage-2 increment of 2 -> o_rd_count=10, and a second read returns 2.
REQ-036 i_enable=0 while mismatches are applied on all lanes -> all counters stay 0 and o_am_error stays 0.
REQ-037 i_rd_lane=N_LANES -> o_rd_valid=1, o_rd_count=0; all counters unchanged.
REQ-038 i_reset asserted mid-accumulation with a pending read -> all outputs 0 the next cycle and no o_rd_valid pulse.
